// File: rtl/sar_avg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sar_avg_pkg
// Purpose  : Shared constants and FSM state encodings for the SAR ADC
//            oversampling averager.
// Revision : 1.0 - initial release
// ============================================================================
package sar_avg_pkg;

  // Sample / result width of the SAR ADC conversion word.
  localparam int SAMPLE_W_DEFAULT = 16;

  // Largest supported block size exponent (N = 64 samples).
  localparam int LOG2_N_MAX = 6;

  // Accumulator FSM: IDLE holds acc/cnt cleared, ACCUM sums samples.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_e;

  // Output register FSM: EMPTY has nothing to offer, FULL holds a result.
  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

endpackage
`default_nettype wire

// File: rtl/sar_avg_accum.sv
`default_nettype none
// ============================================================================
// Module   : sar_avg_accum
// Purpose  : Block accumulator. Sums 2^LOG2_N samples, raises o_done for one
//            cycle on the completing sample and presents the block mean.
// Config   : SAR_AVG_ROUND_EN - round half up instead of truncating.
// Revision : 1.0 - initial release
// ============================================================================
module sar_avg_accum
  import sar_avg_pkg::*;
#(
  parameter int LOG2_N   = 2,
  parameter int SAMPLE_W = SAMPLE_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_enable,
  input  logic [SAMPLE_W-1:0] i_sample,
  input  logic                i_sample_valid,
  output logic                o_done,
  output logic [SAMPLE_W-1:0] o_result
);

  // Wide enough for the sum of N full-scale samples plus the rounding term.
  localparam int ACC_W = SAMPLE_W + LOG2_N;

  acc_state_e       r_state;
  acc_state_e       w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_sum;
  logic [ACC_W-1:0] w_rsum;
  logic             w_take;
  logic             w_last;

  // Samples are taken whenever enabled; the cycle enable rises finds acc
  // already cleared by IDLE, so that sample legitimately opens a block.
  assign w_take = i_enable && i_sample_valid;
  assign w_sum  = r_acc + ACC_W'(i_sample);

  // Accumulator FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Accumulator FSM next state follows the enable level.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_enable)  w_state_nxt = ACCUM;
      ACCUM:   if (!i_enable) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Running sum; cleared when leaving for / sitting in IDLE and on block end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_acc <= '0;
    else if (w_state_nxt == IDLE)  r_acc <= '0;
    else if (w_take)               r_acc <= w_last ? '0 : w_sum;
  end

  if (LOG2_N > 0) begin : g_cnt
    logic [LOG2_N-1:0] r_cnt;

    // Sample counter; wraps to zero on the Nth sample so blocks abut.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   r_cnt <= '0;
      else if (w_state_nxt == IDLE) r_cnt <= '0;
      else if (w_take)              r_cnt <= r_cnt + LOG2_N'(1);
    end

    assign w_last = &r_cnt;
  end else begin : g_no_cnt
    // N = 1: every sample is a complete block.
    assign w_last = 1'b1;
  end

`ifdef SAR_AVG_ROUND_EN
  if (LOG2_N > 0) begin : g_round
    assign w_rsum = w_sum + (ACC_W'(1) << (LOG2_N - 1));
  end else begin : g_round_bypass
    assign w_rsum = w_sum;
  end
`else
  assign w_rsum = w_sum;
`endif

  assign o_done   = w_take && w_last;
  assign o_result = SAMPLE_W'(w_rsum >> LOG2_N);

endmodule
`default_nettype wire

// File: rtl/sar_oversample_avg.sv
`default_nettype none
// ============================================================================
// Module   : sar_oversample_avg
// Purpose  : SAR ADC oversampling averager. Block means are held in a single
//            result register behind a valid/ready handshake; results that
//            arrive while the register is occupied are dropped and flagged.
// Config   : SAR_AVG_ROUND_EN - round half up instead of truncating.
// Revision : 1.0 - initial release
// ============================================================================
module sar_oversample_avg
  import sar_avg_pkg::*;
#(
  parameter int LOG2_N   = 2,
  parameter int SAMPLE_W = SAMPLE_W_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic [SAMPLE_W-1:0] avg_out,
  output logic                avg_valid,
  input  logic                avg_ready,
  output logic                overrun,
  input  logic                clr_overrun
);

  out_state_e          r_out_state;
  out_state_e          w_out_nxt;
  logic [SAMPLE_W-1:0] r_avg;
  logic                r_overrun;
  logic                w_done;
  logic [SAMPLE_W-1:0] w_result;
  logic                w_hs;
  logic                w_load;
  logic                w_drop;

  sar_avg_accum #(
    .LOG2_N   (LOG2_N),
    .SAMPLE_W (SAMPLE_W)
  ) u_accum (
    .clk            (clk),
    .rst_n          (reset),
    .i_enable       (enable),
    .i_sample       (sample_in),
    .i_sample_valid (sample_valid),
    .o_done         (w_done),
    .o_result       (w_result)
  );

  // Output FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_out_state <= EMPTY;
    else        r_out_state <= w_out_nxt;
  end

  // Output FSM: load on completion when the slot is free or being drained
  // this cycle, otherwise drop the new result.
  always_comb begin
    w_out_nxt = r_out_state;
    w_load    = 1'b0;
    w_drop    = 1'b0;
    w_hs      = (r_out_state == FULL) && avg_ready;
    case (r_out_state)
      EMPTY: begin
        if (w_done) begin
          w_load    = 1'b1;
          w_out_nxt = FULL;
        end
      end
      FULL: begin
        if (w_done) begin
          if (w_hs) w_load = 1'b1;
          else      w_drop = 1'b1;
        end else if (w_hs) begin
          w_out_nxt = EMPTY;
        end
      end
      default: w_out_nxt = EMPTY;
    endcase
  end

  // Result register; untouched by drops and by partial-block discards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_avg <= '0;
    else if (w_load) r_avg <= w_result;
  end

  // Sticky overrun flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           r_overrun <= 1'b0;
    else if (w_drop)      r_overrun <= 1'b1;
    else if (clr_overrun) r_overrun <= 1'b0;
  end

  assign avg_out   = r_avg;
  assign avg_valid = (r_out_state == FULL);
  assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sar_oversample_avg.sv
`default_nettype none
// ============================================================================
// Module   : tb_sar_oversample_avg
// Purpose  : Self-checking bench for sar_oversample_avg with LOG2_N = 2.
//            Expected block means come from a hand-computed vector table and
//            from hand-written corner-case sequences; delivered results are
//            checked against a queue on every handshake.
// Config   : SAR_AVG_ROUND_EN selects the rounded expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sar_oversample_avg;

  localparam int LOG2_N   = 2;
  localparam int SAMPLE_W = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic                enable;
  logic [SAMPLE_W-1:0] sample_in;
  logic                sample_valid;
  logic [SAMPLE_W-1:0] avg_out;
  logic                avg_valid;
  logic                avg_ready;
  logic                overrun;
  logic                clr_overrun;

  always #5 clk = ~clk;

  sar_oversample_avg #(
    .LOG2_N   (LOG2_N),
    .SAMPLE_W (SAMPLE_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .avg_out      (avg_out),
    .avg_valid    (avg_valid),
    .avg_ready    (avg_ready),
    .overrun      (overrun),
    .clr_overrun  (clr_overrun)
  );

  // One four-sample block with its truncated and rounded means.
  typedef struct packed {
    logic [3:0][15:0] s;
    logic [15:0]      et;
    logic [15:0]      er;
  } vec_t;

  vec_t        tbl [8];
  logic [15:0] exp_q [$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pick(input vec_t v);
`ifdef SAR_AVG_ROUND_EN
    return v.er;
`else
    return v.et;
`endif
  endfunction

  task automatic set_vec(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d,
                         input logic [15:0] et, input logic [15:0] er);
    tbl[i].s[0] = a;
    tbl[i].s[1] = b;
    tbl[i].s[2] = c;
    tbl[i].s[3] = d;
    tbl[i].et   = et;
    tbl[i].er   = er;
  endtask

  // Drive one cycle of sample input; returns 1 time unit after the edge.
  task automatic put(input logic v_valid, input logic [15:0] v);
    sample_valid = v_valid;
    sample_in    = v;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  // Scoreboard: every handshake must deliver the oldest expected result.
  always @(negedge clk) begin
    if (reset && avg_valid && avg_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got %0d, expected no result", avg_out);
      end else begin
        check("scoreboard", {16'd0, avg_out}, {16'd0, exp_q.pop_front()});
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b0;
    enable       = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    avg_ready    = 1'b1;
    clr_overrun  = 1'b0;

    //            s0       s1       s2       s3       trunc    round
    set_vec(0, 16'd100, 16'd101, 16'd102, 16'd103, 16'd101,   16'd102);
    set_vec(1, 16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF,  16'hFFFF);
    set_vec(2, 16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF,  16'hFFFF);
    set_vec(3, 16'd0,   16'd0,   16'd0,   16'd0,   16'd0,     16'd0);
    set_vec(4, 16'd1,   16'd2,   16'd3,   16'd5,   16'd2,     16'd3);
    set_vec(5, 16'h8000,16'h8000,16'd0,   16'd1,   16'd16384, 16'd16384);
    set_vec(6, 16'd1,   16'd1,   16'd1,   16'd0,   16'd0,     16'd1);
    set_vec(7, 16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFE,16'd65534, 16'hFFFF);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset_avg_out",   {16'd0, avg_out}, 32'd0);
    check("reset_avg_valid", {31'd0, avg_valid}, 32'd0);
    check("reset_overrun",   {31'd0, overrun}, 32'd0);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    enable = 1'b1;
    put(1'b0, 16'd0);

    // Table: back-to-back blocks, consumer always ready.
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (j == 3) exp_q.push_back(pick(tbl[i]));
        put(1'b1, tbl[i].s[j]);
        if (i == 0 && j == 3) begin
          check("latency_valid", {31'd0, avg_valid}, 32'd1);
          check("latency_value", {16'd0, avg_out}, {16'd0, pick(tbl[0])});
        end
        if (i == 1 && j == 0)
          check("valid_one_cycle", {31'd0, avg_valid}, 32'd0);
      end
    end
    repeat (3) put(1'b0, 16'd0);

    // Overrun: consumer stalled across two blocks.
    avg_ready = 1'b0;
    exp_q.push_back(16'd40);
    repeat (4) put(1'b1, 16'd40);
    check("no_overrun_first_block", {31'd0, overrun}, 32'd0);
    repeat (4) put(1'b1, 16'd80);
    check("overrun_set",  {31'd0, overrun}, 32'd1);
    check("overrun_held", {16'd0, avg_out}, 32'd40);
    put(1'b0, 16'd0);
    check("overrun_sticky", {31'd0, overrun}, 32'd1);
    clr_overrun = 1'b1;
    put(1'b0, 16'd0);
    clr_overrun = 1'b0;
    check("overrun_cleared", {31'd0, overrun}, 32'd0);
    check("held_valid", {31'd0, avg_valid}, 32'd1);
    avg_ready = 1'b1;
    put(1'b0, 16'd0);
    check("drained_valid", {31'd0, avg_valid}, 32'd0);

    // Completion in the same cycle as a handshake.
    avg_ready = 1'b0;
    exp_q.push_back(16'd60);
    repeat (4) put(1'b1, 16'd60);
    repeat (3) put(1'b1, 16'd20);
    avg_ready = 1'b1;
    exp_q.push_back(16'd20);
    put(1'b1, 16'd20);
    check("same_cycle_valid",   {31'd0, avg_valid}, 32'd1);
    check("same_cycle_value",   {16'd0, avg_out}, 32'd20);
    check("same_cycle_overrun", {31'd0, overrun}, 32'd0);
    repeat (2) put(1'b0, 16'd0);

    // Enable low for one cycle discards a partial block.
    repeat (2) put(1'b1, 16'd999);
    enable = 1'b0;
    put(1'b1, 16'd999);
    enable = 1'b1;
    exp_q.push_back(16'd200);
    repeat (4) put(1'b1, 16'd200);
    repeat (3) put(1'b0, 16'd0);

    // Reset mid-block with a held result and overrun pending.
    avg_ready = 1'b0;
    repeat (4) put(1'b1, 16'd300);
    repeat (4) put(1'b1, 16'd301);
    repeat (3) put(1'b1, 16'd5000);
    check("pre_reset_overrun", {31'd0, overrun}, 32'd1);
    reset = 1'b0;
    #1;
    check("midreset_avg_out",   {16'd0, avg_out}, 32'd0);
    check("midreset_avg_valid", {31'd0, avg_valid}, 32'd0);
    check("midreset_overrun",   {31'd0, overrun}, 32'd0);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    avg_ready = 1'b1;
    exp_q.push_back(16'd8);
    repeat (4) put(1'b1, 16'd8);
    check("post_reset_value", {16'd0, avg_out}, 32'd8);

    // Let the scoreboard drain, bounded.
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
    repeat (2) @(posedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
